// File: rtl/pattern_detector_fsm.sv
// Run-time programmable serial sequence detector (1..MAX_LEN bit patterns, overlap/non-overlap).
// Define PATTERN_DET_CNT_EN to build the saturating match counter; otherwise match_cnt is tied to 0.
module pattern_detector_fsm #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               disarm,
  input  logic               din,
  input  logic               din_vld,
  output logic               armed,
  output logic               match,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_SEARCH} state_t;

  state_t               state, state_nx;
  logic [MAX_LEN-2:0]   history, history_nx;
  logic [LEN_W-1:0]     fill_cnt, fill_cnt_nx, fill_inc;
  logic [MAX_LEN-1:0]   pat_q, shifted;
  logic [LEN_W-1:0]     len_q;
  logic                 ovl_q;
  logic                 cfg_ok, beat, hit, complete;
  logic                 match_nx, cfg_err_nx, armed_nx;

  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] l);
    logic [MAX_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LEN; i++) m[i] = (i < int'(l));
    return m;
  endfunction

  assign cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign beat     = din_vld && !cfg_load && !disarm && (state != S_IDLE);
  assign shifted  = {history, din};
  assign fill_inc = fill_cnt + LEN_W'(1);
  assign hit      = ((shifted ^ pat_q) & len_mask(len_q)) == '0;
  // The beat that completes the fill window is compared just like a SEARCH beat.
  assign complete = beat && hit && ((state == S_SEARCH) || (fill_inc == len_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      history  <= '0;
      fill_cnt <= '0;
    end else begin
      state    <= state_nx;
      history  <= history_nx;
      fill_cnt <= fill_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    history_nx  = history;
    fill_cnt_nx = fill_cnt;
    if (cfg_load) begin
      if (cfg_ok) begin
        state_nx    = S_FILL;
        history_nx  = '0;
        fill_cnt_nx = '0;
      end
    end else if (disarm) begin
      state_nx    = S_IDLE;
      fill_cnt_nx = '0;
    end else if (beat) begin
      history_nx = shifted[MAX_LEN-2:0];
      if (complete && !ovl_q) begin
        state_nx    = S_FILL;
        fill_cnt_nx = '0;
      end else if (state == S_FILL) begin
        fill_cnt_nx = fill_inc;
        if (fill_inc == len_q) state_nx = S_SEARCH;
      end
    end
  end

  always_comb begin
    match_nx   = complete;
    cfg_err_nx = cfg_load && !cfg_ok;
    armed_nx   = (state_nx != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match   <= 1'b0;
      cfg_err <= 1'b0;
      armed   <= 1'b0;
    end else begin
      match   <= match_nx;
      cfg_err <= cfg_err_nx;
      armed   <= armed_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= '0;
      len_q <= '0;
      ovl_q <= 1'b0;
    end else if (cfg_load && cfg_ok) begin
      pat_q <= cfg_pattern;
      len_q <= cfg_len;
      ovl_q <= cfg_overlap;
    end
  end

`ifdef PATTERN_DET_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt_q <= '0;
    else if (cfg_load && cfg_ok) cnt_q <= '0;
    else if (complete)          cnt_q <= sat_inc(cnt_q);
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_pattern_detector_fsm.sv
// Directed bench for pattern_detector_fsm: a sliding-window reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_pattern_detector_fsm;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;
`ifdef PATTERN_DET_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic               clk, rst_n;
  logic               cfg_load, cfg_overlap, disarm, din, din_vld;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               armed, match, cfg_err;
  logic [CNT_W-1:0]   match_cnt;

  pattern_detector_fsm #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .disarm(disarm), .din(din),
    .din_vld(din_vld), .armed(armed), .match(match), .cfg_err(cfg_err),
    .match_cnt(match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0, npulse = 0;

  // Reference model: last bits seen, count of fresh beats since (re)start of a window.
  bit m_armed, m_ovl, exp_match, exp_err;
  int m_pat, m_len, m_hist, m_fresh, m_cnt;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_armed = 0; m_ovl = 0; exp_match = 0; exp_err = 0;
    m_pat = 0; m_len = 0; m_hist = 0; m_fresh = 0; m_cnt = 0;
  endtask

  task automatic model_step(input int ld, input int pat, input int len, input int ovl,
                            input int dis, input int d, input int v);
    exp_match = 0;
    exp_err   = 0;
    if (ld != 0) begin
      if (len >= 1 && len <= MAX_LEN) begin
        m_pat = pat & 255; m_len = len; m_ovl = (ovl != 0);
        m_hist = 0; m_fresh = 0; m_cnt = 0; m_armed = 1;
      end else exp_err = 1;
    end else if (dis != 0) begin
      m_armed = 0;
      m_fresh = 0;
    end else if (v != 0 && m_armed) begin
      m_hist = ((m_hist << 1) | (d & 1)) & 255;
      m_fresh++;
      if (m_fresh >= m_len && ((m_hist ^ m_pat) & ((1 << m_len) - 1)) == 0) begin
        exp_match = 1;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (!m_ovl) m_fresh = 0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("match",     int'(match),     int'(exp_match));
    chk("cfg_err",   int'(cfg_err),   int'(exp_err));
    chk("armed",     int'(armed),     int'(m_armed));
    chk("match_cnt", int'(match_cnt), CNT_EN ? m_cnt : 0);
  endtask

  task automatic tick(input int ld, input int pat, input int len, input int ovl,
                      input int dis, input int d, input int v);
    cfg_load    = (ld != 0);
    cfg_pattern = MAX_LEN'(pat);
    cfg_len     = LEN_W'(len);
    cfg_overlap = (ovl != 0);
    disarm      = (dis != 0);
    din         = (d != 0);
    din_vld     = (v != 0);
    @(posedge clk);
    model_step(ld, pat, len, ovl, dis, d, v);
    @(negedge clk);
    check_outputs();
    if (match) npulse++;
  endtask

  task automatic load(input int pat, input int len, input int ovl);
    tick(1, pat, len, ovl, 0, 0, 0);
  endtask

  task automatic beat(input int d);
    tick(0, 0, 0, 0, 0, d, 1);
  endtask

  task automatic gap();
    tick(0, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    rst_n = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; disarm = 1'b0; din = 1'b0; din_vld = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_armed", int'(armed), 0);
    chk("reset_match", int'(match), 0);
    chk("reset_err",   int'(cfg_err), 0);
    chk("reset_cnt",   int'(match_cnt), 0);
    rst_n = 1'b1;

    // IDLE ignores data
    beat(1); beat(1);
    chk("idle_armed", int'(armed), 0);

    // 1: overlapping 0101
    load(8'b0101, 4, 1);
    npulse = 0;
    beat(0); beat(1); beat(0); beat(1);
    chk("t1_b4", int'(match), 1);
    beat(0);
    chk("t1_b5", int'(match), 0);
    beat(1);
    chk("t1_b6", int'(match), 1);
    chk("t1_pulses", npulse, 2);
    chk("t1_cnt", int'(match_cnt), CNT_EN ? 2 : 0);
    chk("t1_model_cnt", m_cnt, 2);

    // 2: non-overlapping 0101
    load(8'b0101, 4, 0);
    npulse = 0;
    for (int i = 0; i < 6; i++) beat(i % 2);
    chk("t2_b6", int'(match), 0);
    beat(0); beat(1);
    chk("t2_b8", int'(match), 1);
    chk("t2_pulses", npulse, 2);
    chk("t2_cnt", int'(match_cnt), CNT_EN ? 2 : 0);

    // 3: rejected loads leave everything alone
    tick(1, 8'hFF, 0, 1, 0, 1, 1);
    chk("t3_err0", int'(cfg_err), 1);
    chk("t3_armed0", int'(armed), 1);
    tick(1, 8'hFF, MAX_LEN + 1, 1, 0, 1, 1);
    chk("t3_err9", int'(cfg_err), 1);
    chk("t3_cnt", int'(match_cnt), CNT_EN ? 2 : 0);
    npulse = 0;
    beat(0); beat(1); beat(0); beat(1);
    chk("t3_oldcfg", int'(match), 1);
    chk("t3_err_clr", int'(cfg_err), 0);

    // upper pattern bits beyond len are ignored
    load(8'b1111_1101, 3, 1);
    beat(1); beat(0); beat(1);
    chk("len3_match", int'(match), 1);

    // 4: len=1 with valid gaps
    load(8'h01, 1, 1);
    npulse = 0;
    beat(1); gap();
    chk("t4_gap", int'(match), 0);
    beat(1); gap(); gap(); beat(0); beat(1);
    chk("t4_pulses", npulse, 3);

    // 6: saturation at CNT_W=2
    load(8'h01, 1, 1);
    for (int i = 0; i < 5; i++) beat(1);
    chk("t6_sat", int'(match_cnt), CNT_EN ? 3 : 0);

    // 5a: async reset mid-pattern
    load(8'b0101, 4, 1);
    npulse = 0;
    beat(0); beat(1); beat(0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t5a_armed", int'(armed), 0);
    chk("t5a_match", int'(match), 0);
    chk("t5a_cnt",   int'(match_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    beat(1);
    chk("t5a_nomatch", int'(match), 0);
    chk("t5a_idle", int'(armed), 0);

    // 5b: disarm mid-pattern drops the beat
    load(8'b0101, 4, 1);
    beat(0); beat(1); beat(0);
    tick(0, 0, 0, 0, 1, 1, 1);
    chk("t5b_idle", int'(armed), 0);
    beat(1);
    chk("t5b_nomatch", int'(match), 0);

    // 5c: reload mid-pattern drops the beat and restarts the window
    load(8'b0101, 4, 1);
    beat(0); beat(1); beat(0);
    tick(1, 8'b0101, 4, 1, 0, 1, 1);
    chk("t5c_fill", int'(armed), 1);
    chk("t5c_drop", int'(match), 0);
    beat(1); beat(0); beat(1); beat(0);
    chk("t5c_nomatch", int'(match), 0);
    beat(1);
    chk("t5c_match", int'(match), 1);
    chk("t5_pulses", npulse, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
